// File: rtl/noc_vc_input_buffer.sv
// Virtual-channel input buffer: one circular FIFO per VC, packet-locked round-robin output.
// Malformed flits raise proto_err, flits to a full VC raise overflow_err; both are dropped.
module noc_vc_input_buffer #(
   parameter int unsigned  FLIT_SIZE = 19,
   parameter int unsigned  NUM_VC    = 2,
   parameter int unsigned  DEPTH     = 4,
   localparam int unsigned VC_BITS   = $clog2(NUM_VC),
   localparam int unsigned CNT_BITS  = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FLIT_SIZE-1:0]       in_flit,
   input  logic [VC_BITS-1:0]         in_vc,
   output logic [FLIT_SIZE-1:0]       out_flit,
   output logic [VC_BITS-1:0]         out_vc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_VC-1:0]          credit_out,
   output logic [NUM_VC*CNT_BITS-1:0] vc_count,
   output logic                       proto_err,
   output logic                       overflow_err
);
   localparam int unsigned PTR_BITS = $clog2(DEPTH);

   typedef enum logic [1:0] {T_HEAD = 2'd0, T_TAIL = 2'd1, T_BODY = 2'd2, T_NONE = 2'd3} flit_type_e;
   typedef enum logic {S_IDLE, S_LOCKED} state_e;

   logic [FLIT_SIZE-1:0] r_mem [NUM_VC][DEPTH];
   logic [PTR_BITS-1:0]  r_wr_ptr [NUM_VC];
   logic [PTR_BITS-1:0]  r_rd_ptr [NUM_VC];
   logic [CNT_BITS-1:0]  r_count  [NUM_VC];
   logic [NUM_VC-1:0]    r_in_open;

   state_e               r_state, w_state_nxt;
   logic [VC_BITS-1:0]   r_lock_vc, w_lock_vc_nxt;
   logic [VC_BITS-1:0]   r_rr_ptr, w_rr_ptr_nxt;
   logic [VC_BITS-1:0]   r_hold_vc, w_hold_vc_nxt;
   logic                 r_hold, w_hold_nxt;

   flit_type_e           w_in_type, w_out_type;
   logic                 w_attempt, w_vc_ok, w_open, w_full;
   logic                 w_push, w_proto, w_ovf;
   logic [NUM_VC-1:0]    w_push_vec, w_pop;
   logic [VC_BITS-1:0]   w_grant, w_sel;
   logic                 w_any, w_valid;
   logic [FLIT_SIZE-1:0] w_out_flit;

   // Input classification: well-formed flits push unless the VC was full at cycle start
   assign w_in_type = flit_type_e'(in_flit[FLIT_SIZE-2 -: 2]);
   assign w_attempt = in_flit[FLIT_SIZE-1] && (w_in_type != T_NONE);
   assign w_vc_ok   = 32'(in_vc) < NUM_VC;
   assign w_open    = w_vc_ok ? r_in_open[in_vc] : 1'b0;
   assign w_full    = w_vc_ok && (r_count[in_vc] == CNT_BITS'(DEPTH));

   always_comb begin
      w_proto    = 1'b0;
      w_ovf      = 1'b0;
      w_push     = 1'b0;
      w_push_vec = '0;
      if (w_attempt) begin
         if (!w_vc_ok || ((w_in_type == T_HEAD) == w_open)) w_proto = 1'b1;
         else if (w_full)                                   w_ovf   = 1'b1;
         else                                               w_push  = 1'b1;
      end
      if (w_push) w_push_vec[in_vc] = 1'b1;
   end

   always_comb begin
      w_grant = r_rr_ptr;
      w_any   = 1'b0;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
         if (!w_any && (r_count[VC_BITS'((32'(r_rr_ptr) + i) % NUM_VC)] != '0)) begin
            w_grant = VC_BITS'((32'(r_rr_ptr) + i) % NUM_VC);
            w_any   = 1'b1;
         end
      end
   end

   // A stalled IDLE grant is held so a newly filled VC cannot steal the output
   always_comb begin
      w_state_nxt   = r_state;
      w_lock_vc_nxt = r_lock_vc;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_hold_nxt    = 1'b0;
      w_hold_vc_nxt = r_hold_vc;
      w_sel         = w_grant;
      w_valid       = w_any;
      w_pop         = '0;
      unique case (r_state)
         S_IDLE: begin
            if (r_hold) begin
               w_sel   = r_hold_vc;
               w_valid = 1'b1;
            end
            w_hold_nxt    = w_valid && !out_ready;
            w_hold_vc_nxt = w_sel;
         end
         S_LOCKED: begin
            w_sel   = r_lock_vc;
            w_valid = (r_count[r_lock_vc] != '0);
         end
      endcase
      w_out_flit = r_mem[w_sel][r_rd_ptr[w_sel]];
      w_out_type = flit_type_e'(w_out_flit[FLIT_SIZE-2 -: 2]);
      if (w_valid && out_ready) begin
         w_pop[w_sel] = 1'b1;
         if (r_state == S_IDLE && w_out_type == T_HEAD) begin
            w_state_nxt   = S_LOCKED;
            w_lock_vc_nxt = w_sel;
         end else if (r_state == S_LOCKED && w_out_type == T_TAIL) begin
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = VC_BITS'((32'(r_lock_vc) + 1) % NUM_VC);
         end
      end
   end

   assign out_valid = w_valid;
   assign out_flit  = w_valid ? w_out_flit : '0;
   assign out_vc    = w_valid ? w_sel : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_lock_vc <= '0;
         r_rr_ptr  <= '0;
         r_hold    <= 1'b0;
         r_hold_vc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_vc <= w_lock_vc_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_hold    <= w_hold_nxt;
         r_hold_vc <= w_hold_vc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_open    <= '0;
         credit_out   <= '0;
         proto_err    <= 1'b0;
         overflow_err <= 1'b0;
         for (int unsigned k = 0; k < NUM_VC; k++) begin
            r_wr_ptr[k] <= '0;
            r_rd_ptr[k] <= '0;
            r_count[k]  <= '0;
         end
      end else begin
         credit_out   <= w_pop;
         proto_err    <= w_proto;
         overflow_err <= w_ovf;
         for (int unsigned k = 0; k < NUM_VC; k++) begin
            if (w_push_vec[k]) begin
               r_wr_ptr[k] <= r_wr_ptr[k] + PTR_BITS'(1);
               if (w_in_type == T_HEAD)      r_in_open[k] <= 1'b1;
               else if (w_in_type == T_TAIL) r_in_open[k] <= 1'b0;
            end
            if (w_pop[k]) r_rd_ptr[k] <= r_rd_ptr[k] + PTR_BITS'(1);
            r_count[k] <= r_count[k] + CNT_BITS'(w_push_vec[k]) - CNT_BITS'(w_pop[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[in_vc][r_wr_ptr[in_vc]] <= in_flit;
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_VC; k++) vc_count[k*CNT_BITS +: CNT_BITS] = r_count[k];
   end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench for noc_vc_input_buffer: vector table plus hand sequences for
// multi-VC ordering and reset while a packet is locked.
module tb_noc_vc_input_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] in_flit;
   logic [0:0]  in_vc;
   logic [18:0] out_flit;
   logic [0:0]  out_vc;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  credit_out;
   logic [5:0]  vc_count;
   logic        proto_err;
   logic        overflow_err;

   int n_tests = 0;
   int n_fail  = 0;

   noc_vc_input_buffer #(.FLIT_SIZE(19), .NUM_VC(2), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_vc(in_vc),
      .out_flit(out_flit), .out_vc(out_vc), .out_valid(out_valid), .out_ready(out_ready),
      .credit_out(credit_out), .vc_count(vc_count), .proto_err(proto_err),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [18:0] flit;
      logic        vc;
      logic        rdy;
      logic        ev;
      logic [18:0] ef;
      logic        evc;
      logic [1:0]  ec;
      logic        ep;
      logic        eo;
      logic [5:0]  ecnt;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];

   function automatic logic [18:0] fh(input logic [15:0] p); return {1'b1, 2'd0, p}; endfunction
   function automatic logic [18:0] ft(input logic [15:0] p); return {1'b1, 2'd1, p}; endfunction
   function automatic logic [18:0] fb(input logic [15:0] p); return {1'b1, 2'd2, p}; endfunction

   function automatic vec_t mv(input logic r, input logic [18:0] f, input logic vc, input logic rdy,
                               input logic ev, input logic [18:0] ef, input logic evc,
                               input logic [1:0] ec, input logic ep, input logic eo,
                               input logic [5:0] ecnt);
      vec_t v;
      v.rst = r; v.flit = f; v.vc = vc; v.rdy = rdy;
      v.ev = ev; v.ef = ef; v.evc = evc; v.ec = ec; v.ep = ep; v.eo = eo; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic ev, input logic [18:0] ef, input logic evc,
                        input logic [1:0] ec, input logic ep, input logic eo, input logic [5:0] ecnt);
      n_tests++;
      if ({out_valid, out_flit, out_vc, credit_out, proto_err, overflow_err, vc_count} !==
          {ev, ef, evc, ec, ep, eo, ecnt}) begin
         n_fail++;
         $display("FAIL %s: got v=%b flit=%h vc=%0d cred=%b perr=%b oerr=%b cnt=%h; want v=%b flit=%h vc=%0d cred=%b perr=%b oerr=%b cnt=%h",
                  name, out_valid, out_flit, out_vc, credit_out, proto_err, overflow_err, vc_count,
                  ev, ef, evc, ec, ep, eo, ecnt);
      end
   endtask

   task automatic drive(input logic r, input logic [18:0] f, input logic vc, input logic rdy);
      rst = r; in_flit = f; in_vc = vc; out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [18:0] exp_fl [5];
      logic        exp_vc [5];
      logic [18:0] got_fl [5];
      logic        got_vc [5];
      int          n_got;

      // rst flit vc rdy | valid flit vc cred perr oerr cnt
      vecs[0]  = mv(1, 19'h0, 0, 0,  0, 19'h0, 0, 2'b00, 0, 0, 6'h00);
      vecs[1]  = mv(0, fh(16'hA001), 0, 1,  1, fh(16'hA001), 0, 2'b00, 0, 0, 6'h01);
      vecs[2]  = mv(0, fb(16'hA002), 0, 1,  1, fb(16'hA002), 0, 2'b01, 0, 0, 6'h01);
      vecs[3]  = mv(0, fb(16'hA003), 0, 1,  1, fb(16'hA003), 0, 2'b01, 0, 0, 6'h01);
      vecs[4]  = mv(0, ft(16'hA004), 0, 1,  1, ft(16'hA004), 0, 2'b01, 0, 0, 6'h01);
      vecs[5]  = mv(0, 19'h0, 0, 1,  0, 19'h0, 0, 2'b01, 0, 0, 6'h00);
      vecs[6]  = mv(0, 19'h0, 0, 1,  0, 19'h0, 0, 2'b00, 0, 0, 6'h00);
      vecs[7]  = mv(0, fb(16'h0B00), 0, 0,  0, 19'h0, 0, 2'b00, 1, 0, 6'h00);
      vecs[8]  = mv(0, fh(16'hC001), 0, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h01);
      vecs[9]  = mv(0, fh(16'hC002), 0, 0,  1, fh(16'hC001), 0, 2'b00, 1, 0, 6'h01);
      vecs[10] = mv(0, 19'h0, 0, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h01);
      vecs[11] = mv(0, fh(16'hD001), 1, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h09);
      vecs[12] = mv(0, fb(16'hD002), 1, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h11);
      vecs[13] = mv(0, fb(16'hD003), 1, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h19);
      vecs[14] = mv(0, fb(16'hD004), 1, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h21);
      vecs[15] = mv(0, fb(16'hD005), 1, 0,  1, fh(16'hC001), 0, 2'b00, 0, 1, 6'h21);
      vecs[16] = mv(0, 19'h0, 0, 0,  1, fh(16'hC001), 0, 2'b00, 0, 0, 6'h21);
      vecs[17] = mv(0, 19'h0, 0, 1,  0, 19'h0, 0, 2'b01, 0, 0, 6'h20);
      vecs[18] = mv(0, ft(16'hC003), 0, 1,  1, ft(16'hC003), 0, 2'b00, 0, 0, 6'h21);
      vecs[19] = mv(0, 19'h0, 0, 1,  1, fh(16'hD001), 1, 2'b01, 0, 0, 6'h20);
      vecs[20] = mv(0, fb(16'hD05B), 1, 1,  1, fb(16'hD002), 1, 2'b10, 0, 1, 6'h18);
      vecs[21] = mv(0, 19'h0, 0, 0,  1, fb(16'hD002), 1, 2'b00, 0, 0, 6'h18);
      vecs[22] = mv(0, 19'h0, 0, 0,  1, fb(16'hD002), 1, 2'b00, 0, 0, 6'h18);
      vecs[23] = mv(0, 19'h0, 0, 0,  1, fb(16'hD002), 1, 2'b00, 0, 0, 6'h18);
      vecs[24] = mv(0, 19'h0, 0, 1,  1, fb(16'hD003), 1, 2'b10, 0, 0, 6'h10);
      vecs[25] = mv(0, 19'h0, 0, 1,  1, fb(16'hD004), 1, 2'b10, 0, 0, 6'h08);
      vecs[26] = mv(0, 19'h0, 0, 1,  0, 19'h0, 0, 2'b10, 0, 0, 6'h00);
      vecs[27] = mv(0, ft(16'hD006), 1, 1,  1, ft(16'hD006), 1, 2'b00, 0, 0, 6'h08);
      vecs[28] = mv(0, 19'h0, 0, 1,  0, 19'h0, 0, 2'b10, 0, 0, 6'h00);
      vecs[29] = mv(0, {1'b0, 2'd0, 16'hE0E0}, 0, 1,  0, 19'h0, 0, 2'b00, 0, 0, 6'h00);
      vecs[30] = mv(0, {1'b1, 2'd3, 16'hE0E1}, 0, 1,  0, 19'h0, 0, 2'b00, 0, 0, 6'h00);
      vecs[31] = mv(0, 19'h0, 0, 1,  0, 19'h0, 0, 2'b00, 0, 0, 6'h00);

      drive(1, 19'h0, 0, 0);
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].flit, vecs[i].vc, vecs[i].rdy);
         tick();
         check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ef, vecs[i].evc, vecs[i].ec,
               vecs[i].ep, vecs[i].eo, vecs[i].ecnt);
      end

      // Two packets queued on both VCs: VC0 drains whole, then VC1
      exp_fl[0] = fh(16'hE000); exp_vc[0] = 1'b0;
      exp_fl[1] = fb(16'hE001); exp_vc[1] = 1'b0;
      exp_fl[2] = ft(16'hE002); exp_vc[2] = 1'b0;
      exp_fl[3] = fh(16'hF000); exp_vc[3] = 1'b1;
      exp_fl[4] = ft(16'hF001); exp_vc[4] = 1'b1;
      drive(1, 19'h0, 0, 0); tick();
      drive(0, fh(16'hE000), 0, 0); tick();
      drive(0, fh(16'hF000), 1, 0); tick();
      drive(0, fb(16'hE001), 0, 0); tick();
      drive(0, ft(16'hF001), 1, 0); tick();
      drive(0, ft(16'hE002), 0, 0); tick();
      check("mvc_queued", 1, fh(16'hE000), 0, 2'b00, 0, 0, 6'h13);
      drive(0, 19'h0, 0, 1);
      n_got = 0;
      for (int c = 0; c < 20 && n_got < 5; c++) begin
         if (out_valid) begin
            got_fl[n_got] = out_flit;
            got_vc[n_got] = out_vc[0];
            n_got++;
         end
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (i >= n_got) begin
            n_fail++;
            $display("FAIL mvc_order%0d: no transfer seen, want vc=%0d flit=%h", i, exp_vc[i], exp_fl[i]);
         end else if (got_fl[i] !== exp_fl[i] || got_vc[i] !== exp_vc[i]) begin
            n_fail++;
            $display("FAIL mvc_order%0d: got vc=%0d flit=%h, want vc=%0d flit=%h",
                     i, got_vc[i], got_fl[i], exp_vc[i], exp_fl[i]);
         end
      end
      drive(0, 19'h0, 0, 0); tick();
      check("mvc_drained", 0, 19'h0, 0, 2'b00, 0, 0, 6'h00);

      // Reset while locked with two flits buffered, then a fresh packet on VC1
      drive(0, fh(16'h6000), 0, 0); tick();
      drive(0, fb(16'h6001), 0, 0); tick();
      drive(0, fb(16'h6002), 0, 1); tick();
      check("lock_pre_rst", 1, fb(16'h6001), 0, 2'b01, 0, 0, 6'h02);
      drive(1, 19'h0, 0, 0); tick();
      check("rst_in_lock", 0, 19'h0, 0, 2'b00, 0, 0, 6'h00);
      drive(0, fh(16'h6003), 1, 0); tick();
      check("post_rst_head", 1, fh(16'h6003), 1, 2'b00, 0, 0, 6'h08);
      drive(0, fb(16'h6004), 0, 0); tick();
      check("post_rst_closed", 1, fh(16'h6003), 1, 2'b00, 1, 0, 6'h08);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
